fadd_align: RTL
===============

FADD_ALIGN -- requirements
Module: fadd_align

Interface
REQ-001 SHALL have parameter N, default 32, giving operand width; legal values are 32 (1/8/23) and 64 (1/11/52).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning operand pair a/b present.
REQ-005 SHALL have port in_ready, output, 1, meaning block accepts a/b this cycle.
REQ-006 SHALL have ports a and b, input, N each, IEEE-754 operands.
REQ-007 SHALL have port out_valid, output, 1, meaning aligned result fields valid.
REQ-008 SHALL have port out_ready, input, 1, meaning the downstream adder stage consumes this cycle.
REQ-009 SHALL have port big_sign, output, 1, the sign of the larger-magnitude operand.
REQ-010 SHALL have port big_exp, output, E (8/11), the exponent of the larger-magnitude operand.
REQ-011 SHALL have port big_man, output, M+1, the larger mantissa with hidden bit.
REQ-012 SHALL have port sml_man, output, M+4, the smaller mantissa with hidden bit, right-shifted, followed by guard, round and sticky bits.
REQ-013 SHALL have port eff_sub, output, 1, asserted when the operand signs differ.
REQ-014 SHALL have ports special and special_res, outputs, 1 and N; when special=1, special_res is the final sum.

Function
REQ-015 SHALL transfer input on in_valid&&in_ready and output on out_valid&&out_ready.
REQ-016 SHALL be a 2-stage pipeline: S1 classifies and swaps, S2 aligns; latency is exactly 2 cycles with no stall.
REQ-017 SHALL sustain throughput of 1 pair/cycle while out_ready=1.
REQ-018 SHALL compute in_ready = !(S1 full && S2 full && !out_ready); a full pipeline holds all registers unchanged while stalled.
REQ-019 SHALL never drop or duplicate a pair; output fields SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 SHALL classify each operand as zero (exp=0, including flush of subnormals), inf (exp all-ones, man=0), nan (exp all-ones, man!=0), or normal.
REQ-021 SHALL select as "big" the operand with the larger {exp,man}; on a tie, a is big.
REQ-022 SHALL compute d = big_exp - sml_exp as unsigned E bits; d=0 means no shift.
REQ-023 SHALL, for d <= M+3, shift {1,sml_man,000} right by d and OR every bit shifted out into sticky.
REQ-024 SHALL, for d > M+3, force sml_man to zero with sticky=1.
REQ-025 SHALL set special=1 with these results, in priority order:
  - any nan -> all-ones;
  - inf + opposite-sign inf -> all-ones;
  - any inf -> that inf;
  - both zero -> -0 only if both signs are 1, else +0;
  - one zero -> the other operand.
REQ-026 SHALL hold alignment fields at zero when special=1.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, clear both stage valids, drive out_valid=0 and in_ready=1 on the next cycle, and clear all data outputs to 0.
REQ-028 SHALL discard any pairs in flight when rst asserts mid-operation; in_valid is ignored during reset.

Structure
REQ-029 SHALL take the field widths (E, M, shift range M+3) and the operand class enum {ZERO, NORM, INF, NAN} from shared package fp_pkg, selected by N.
REQ-030 SHALL instantiate one sub-module, fp_classify, once per operand; it is combinational, takes an N-bit operand, and returns the class, exponent and mantissa.

Verification
REQ-031 SHALL cover: a=0x3F800000, b=0x3FC00000 -> 2 cycles later big_exp=127, big_man=0xC00000, sml_man={0x800000,000}, eff_sub=0, special=0.
REQ-032 SHALL cover: a=0x3F800000, b=0x30800000 (d=30>26) -> sml_man=0 with sticky=1, big_exp=127.
REQ-033 SHALL cover: a=0x7F800000, b=0xFF800000 -> special=1, special_res=0xFFFFFFFF; and a=0x80000000, b=0x80000000 -> special_res=0x80000000.
REQ-034 SHALL cover: 4 back-to-back pairs, out_ready=0 for cycles 2-4 -> in_ready=0 while full, all 4 results emerge in order, unchanged while stalled.
REQ-035 SHALL cover: rst asserted with 2 pairs in flight -> out_valid=0 next cycle, no stale result emitted; a pair issued after reset is released with 2-cycle latency.
REQ-036 SHALL cover: N=64, a=0x3FF0000000000000, b=0xBFF8000000000000 -> big is b, eff_sub=1, big_exp=1023, d=0.

Source files
------------

// File: rtl/fp_pkg.sv
// ============================================================================
//  fp_pkg : shared field widths and operand classes for fadd_align
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  // Only the binary32 and binary64 formats are supported.
  function automatic int exp_w(input int n);
    return (n == 64) ? 11 : 8;
  endfunction

  function automatic int man_w(input int n);
    return (n == 64) ? 52 : 23;
  endfunction

  function automatic int shift_max(input int n);
    return man_w(n) + 3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_classify.sv
// ============================================================================
//  fp_classify : splits an IEEE-754 operand into fields and classifies it
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fp_classify
  import fp_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]          op_i,
  output logic                  sign_o,
  output fp_class_e             cls_o,
  output logic [exp_w(N)-1:0]   exp_o,
  output logic [man_w(N)-1:0]   man_o
);

  localparam int E = exp_w(N);
  localparam int M = man_w(N);

  assign sign_o = op_i[N-1];
  assign exp_o  = op_i[M +: E];
  assign man_o  = op_i[M-1:0];

  // Subnormals share the zero class: they are flushed.
  always_comb begin
    if (exp_o == '0) begin
      cls_o = ZERO;
    end else if (exp_o == '1) begin
      cls_o = (man_o == '0) ? INF : NAN;
    end else begin
      cls_o = NORM;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fadd_align.sv
// ============================================================================
//  fadd_align : two-stage FP adder front end (classify/swap, then align)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fadd_align
  import fp_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          a,
  input  logic [N-1:0]          b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  big_sign,
  output logic [exp_w(N)-1:0]   big_exp,
  output logic [man_w(N):0]     big_man,
  output logic [man_w(N)+3:0]   sml_man,
  output logic                  eff_sub,
  output logic                  special,
  output logic [N-1:0]          special_res
);

  localparam int            E      = exp_w(N);
  localparam int            M      = man_w(N);
  localparam logic [E-1:0]  SH_MAX = E'(shift_max(N));

  logic            w_sign_a, w_sign_b;
  fp_class_e       w_cls_a, w_cls_b;
  logic [E-1:0]    w_exp_a, w_exp_b;
  logic [M-1:0]    w_man_a, w_man_b;

  fp_classify #(.N(N)) u_cls_a (
    .op_i(a), .sign_o(w_sign_a), .cls_o(w_cls_a), .exp_o(w_exp_a), .man_o(w_man_a)
  );

  fp_classify #(.N(N)) u_cls_b (
    .op_i(b), .sign_o(w_sign_b), .cls_o(w_cls_b), .exp_o(w_exp_b), .man_o(w_man_b)
  );

  // Stage 1 state
  logic            s1_valid_q;
  logic            s1_special_q, s1_special_d;
  logic [N-1:0]    s1_res_q, s1_res_d;
  logic            s1_big_sign_q, s1_big_sign_d;
  logic [E-1:0]    s1_big_exp_q, s1_big_exp_d;
  logic [M:0]      s1_big_man_q, s1_big_man_d;
  logic [E-1:0]    s1_sml_exp_q, s1_sml_exp_d;
  logic [M-1:0]    s1_sml_man_q, s1_sml_man_d;
  logic            s1_eff_sub_q, s1_eff_sub_d;

  // Stage 2 state (drives the outputs directly)
  logic            s2_valid_q;
  logic            s2_special_q;
  logic [N-1:0]    s2_res_q;
  logic            s2_big_sign_q;
  logic [E-1:0]    s2_big_exp_q;
  logic [M:0]      s2_big_man_q;
  logic [M+3:0]    s2_sml_man_q;
  logic            s2_eff_sub_q;

  logic            w_s1_en, w_s2_en, w_a_big;

  assign w_s2_en  = !s2_valid_q || out_ready;
  assign w_s1_en  = !s1_valid_q || w_s2_en;
  assign in_ready = w_s1_en;
  assign w_a_big  = {w_exp_a, w_man_a} >= {w_exp_b, w_man_b};

  always_comb begin
    s1_special_d  = 1'b1;
    s1_res_d      = '0;
    s1_big_sign_d = 1'b0;
    s1_big_exp_d  = '0;
    s1_big_man_d  = '0;
    s1_sml_exp_d  = '0;
    s1_sml_man_d  = '0;
    s1_eff_sub_d  = 1'b0;
    if (w_cls_a == NAN || w_cls_b == NAN) begin
      s1_res_d = '1;
    end else if (w_cls_a == INF && w_cls_b == INF && w_sign_a != w_sign_b) begin
      s1_res_d = '1;
    end else if (w_cls_a == INF) begin
      s1_res_d = a;
    end else if (w_cls_b == INF) begin
      s1_res_d = b;
    end else if (w_cls_a == ZERO && w_cls_b == ZERO) begin
      s1_res_d = {w_sign_a & w_sign_b, {(N-1){1'b0}}};
    end else if (w_cls_a == ZERO) begin
      s1_res_d = b;
    end else if (w_cls_b == ZERO) begin
      s1_res_d = a;
    end else begin
      s1_special_d  = 1'b0;
      s1_eff_sub_d  = w_sign_a ^ w_sign_b;
      s1_big_sign_d = w_a_big ? w_sign_a : w_sign_b;
      s1_big_exp_d  = w_a_big ? w_exp_a : w_exp_b;
      s1_big_man_d  = {1'b1, (w_a_big ? w_man_a : w_man_b)};
      s1_sml_exp_d  = w_a_big ? w_exp_b : w_exp_a;
      s1_sml_man_d  = w_a_big ? w_man_b : w_man_a;
    end
  end

  logic [E-1:0]    w_d;
  logic [M+3:0]    w_ext, w_shifted, w_lost, w_aligned;

  // Bits pushed past the sticky position are folded back into it.
  always_comb begin
    w_d       = s1_big_exp_q - s1_sml_exp_q;
    w_ext     = {1'b1, s1_sml_man_q, 3'b000};
    w_shifted = w_ext >> w_d;
    w_lost    = w_ext & ~({(M+4){1'b1}} << w_d);
    if (s1_special_q) begin
      w_aligned = '0;
    end else if (w_d > SH_MAX) begin
      w_aligned = {{(M+3){1'b0}}, 1'b1};
    end else begin
      w_aligned = {w_shifted[M+3:1], w_shifted[0] | (|w_lost)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_special_q  <= 1'b0;
      s1_res_q      <= '0;
      s1_big_sign_q <= 1'b0;
      s1_big_exp_q  <= '0;
      s1_big_man_q  <= '0;
      s1_sml_exp_q  <= '0;
      s1_sml_man_q  <= '0;
      s1_eff_sub_q  <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_special_q  <= 1'b0;
      s2_res_q      <= '0;
      s2_big_sign_q <= 1'b0;
      s2_big_exp_q  <= '0;
      s2_big_man_q  <= '0;
      s2_sml_man_q  <= '0;
      s2_eff_sub_q  <= 1'b0;
    end else begin
      if (w_s1_en) begin
        s1_valid_q    <= in_valid;
        s1_special_q  <= s1_special_d;
        s1_res_q      <= s1_res_d;
        s1_big_sign_q <= s1_big_sign_d;
        s1_big_exp_q  <= s1_big_exp_d;
        s1_big_man_q  <= s1_big_man_d;
        s1_sml_exp_q  <= s1_sml_exp_d;
        s1_sml_man_q  <= s1_sml_man_d;
        s1_eff_sub_q  <= s1_eff_sub_d;
      end
      if (w_s2_en) begin
        s2_valid_q    <= s1_valid_q;
        s2_special_q  <= s1_special_q;
        s2_res_q      <= s1_res_q;
        s2_big_sign_q <= s1_big_sign_q;
        s2_big_exp_q  <= s1_big_exp_q;
        s2_big_man_q  <= s1_big_man_q;
        s2_sml_man_q  <= w_aligned;
        s2_eff_sub_q  <= s1_eff_sub_q;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign special     = s2_special_q;
  assign special_res = s2_res_q;
  assign big_sign    = s2_big_sign_q;
  assign big_exp     = s2_big_exp_q;
  assign big_man     = s2_big_man_q;
  assign sml_man     = s2_sml_man_q;
  assign eff_sub     = s2_eff_sub_q;

endmodule

`default_nettype wire
